// File: rtl/div_seq_pkg.sv
// Shared encodings for the multi-cycle divider sequencer.
package div_seq_pkg;

  // 2-bit state encoding shared with the EX stage decode.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BYZERO  = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_SIGNED           = 1'b1;
  localparam logic DIV_UNSIGNED         = 1'b0;

endpackage

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU.
// Returns {remainder, quotient}; holds the result until EX drops start.
//
// state  | meaning
// FREE   | idle, waiting for start; outputs zero
// BYZERO | divisor was zero; result forced to zero next edge
// ON     | one shift/subtract iteration per cycle, WIDTH iterations
// END    | result valid, held while start stays high
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH:0]     dvd_q;
  logic [WIDTH-1:0]     divisor_q;
  logic                 signed_q;
  logic                 op1_neg_q;
  logic                 op2_neg_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;

  logic [WIDTH:0]       diff;
  logic [2*WIDTH:0]     dvd_d;
  logic [WIDTH-1:0]     op1_abs;
  logic [WIDTH-1:0]     op2_abs;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Two's complement; 0x80000000 maps to itself, which reads as 2^31 unsigned.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Operand magnitudes taken at acceptance.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i == DIV_SIGNED && opdata1_i[WIDTH-1]) op1_abs = neg(opdata1_i);
    if (signed_div_i == DIV_SIGNED && opdata2_i[WIDTH-1]) op2_abs = neg(opdata2_i);
  end

  // Trial subtract of the divisor from the current partial remainder.
  always_comb begin
    diff  = {1'b0, dvd_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
    dvd_d = dvd_q << 1;
    if (!diff[WIDTH]) dvd_d = {diff[WIDTH-1:0], dvd_q[WIDTH-1:0], 1'b1};
  end

  // Sign fix-up applied when the last iteration has completed.
  always_comb begin
    quo_fix = dvd_q[WIDTH-1:0];
    rem_fix = dvd_q[2*WIDTH:WIDTH+1];
    if (signed_q == DIV_SIGNED && (op1_neg_q ^ op2_neg_q)) quo_fix = neg(dvd_q[WIDTH-1:0]);
    if (signed_q == DIV_SIGNED && op1_neg_q) rem_fix = neg(dvd_q[2*WIDTH:WIDTH+1]);
  end

  // Sequencer FSM with registered result and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      divisor_q <= '0;
      signed_q  <= DIV_UNSIGNED;
      op1_neg_q <= 1'b0;
      op2_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else if (annul_i) begin
      // A flush abandons any work; in FREE it simply blocks acceptance.
      state_q  <= DIV_FREE;
      result_q <= '0;
      ready_q  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state_q)
        DIV_FREE: begin
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q   <= DIV_ON;
              cnt_q     <= '0;
              divisor_q <= op2_abs;
              dvd_q     <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
              signed_q  <= signed_div_i;
              op1_neg_q <= opdata1_i[WIDTH-1];
              op2_neg_q <= opdata2_i[WIDTH-1];
            end
          end
        end
        DIV_BYZERO: begin
          state_q  <= DIV_END;
          result_q <= '0;
          ready_q  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (cnt_q != CNT_W'(WIDTH)) begin
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q  <= DIV_END;
            cnt_q    <= '0;
            result_q <= {rem_fix, quo_fix};
            ready_q  <= DIV_RESULT_READY;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
          end
        end
        default: begin
          state_q  <= DIV_FREE;
          result_q <= '0;
          ready_q  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
